// File: rtl/encoder_event_fifo_if.sv
// encoder_event_fifo_if: encoder inputs plus consumer handshake and status of the event FIFO
interface encoder_event_fifo_if #(parameter int AW = 2);
  logic          D1;
  logic          D2;
  logic          D3;
  logic          val;
  logic          out_ready;
  logic          clr_ovf;
  logic [2:0]    out_code;
  logic          out_valid;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  modport master (output D1, D2, D3, val, out_ready, clr_ovf,
                  input out_code, out_valid, count, full, overflow);
  modport slave  (input D1, D2, D3, val, out_ready, clr_ovf,
                  output out_code, out_valid, count, full, overflow);
endinterface

// File: rtl/encoder_event_fifo.sv
// encoder_event_fifo: registers encoder outputs, turns new valid codes into events, buffers them in a FWFT FIFO
module encoder_event_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                clk,
  input logic                rst_n,
  encoder_event_fifo_if.slave bus
);
  logic [3:0]    s1, s2;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf, evt, full, pop, push;
  // a new event is a valid code that was not valid, or was a different code, one cycle earlier
  assign evt  = s1[3] & (~s2[3] | (s1[2:0] != s2[2:0]));
  assign full = cnt == (AW+1)'(DEPTH);
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = evt & (~full | pop);
  assign bus.out_valid = cnt != '0;
  assign bus.out_code  = bus.out_valid ? mem[rd_ptr] : 3'b000;
  assign bus.count     = cnt;
  assign bus.full      = full;
  assign bus.overflow  = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1 <= {bus.val, bus.D3, bus.D2, bus.D1};
      s2 <= s1;
      if (push) begin
        mem[wr_ptr] <= s1[2:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= (push & ~pop) ? cnt + (AW+1)'(1) : (pop & ~push) ? cnt - (AW+1)'(1) : cnt;
      ovf <= (evt & ~push) ? 1'b1 : bus.clr_ovf ? 1'b0 : ovf;
    end
  end
endmodule
